// File: rtl/expression_unpacker_if.sv
// Stream bundle between a packed-word producer and the expression unpacker:
// one 90-bit word in, 18 extended field beats out.
interface expression_unpacker_if;
    logic        in_valid;
    logic        in_ready;
    logic [89:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [4:0]  out_idx;
    logic        out_signed;
    logic        out_last;

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_signed, out_last
    );

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_signed, out_last
    );
endinterface

// File: rtl/expression_unpacker.sv
// Serializes a packed {y0..y17} result word into 18 zero/sign-extended 8-bit beats, MSB field first.
// Optional running field sum on out_sum when UNPACK_SUM_EN is defined.
module expression_unpacker (
    input  logic                 clk,
    input  logic                 reset,
    expression_unpacker_if.slave bus,
`ifdef UNPACK_SUM_EN
    output logic [11:0]          out_sum,
`endif
    output logic                 busy
);
    typedef enum logic {IDLE, EMIT} state_t;

    // Bit k set when field k is a signed type (fields 3-5, 9-11, 15-17).
    localparam logic [17:0] SIGNED_MASK = 18'b111000111000111000;

    state_t      state;
    state_t      state_next;
    logic [89:0] word;
    logic [4:0]  idx;
    logic [1:0]  phase;
    logic        is_signed;
    logic        accept;
    logic        advance;
    logic [7:0]  field_ext;

    // The current field always sits at the top of the shift register; phase = idx % 3 picks its width.
    always_comb begin
        field_ext = 8'd0;
        is_signed = SIGNED_MASK[idx];
        case (phase)
            2'd1:    field_ext = {{3{is_signed & word[89]}}, word[89:85]};
            2'd2:    field_ext = {{2{is_signed & word[89]}}, word[89:84]};
            default: field_ext = {{4{is_signed & word[89]}}, word[89:86]};
        endcase
    end

    always_comb begin
        bus.out_valid  = (state == EMIT);
        bus.out_data   = field_ext;
        bus.out_idx    = idx;
        bus.out_signed = is_signed;
        bus.out_last   = (idx == 5'd17);
        bus.in_ready   = (state == IDLE) || (bus.out_ready && bus.out_last && state == EMIT);
        busy           = (state == EMIT);
    end

    assign accept  = bus.in_valid && bus.in_ready;
    assign advance = bus.out_valid && bus.out_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EMIT;
            EMIT:    if (advance && bus.out_last && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: the word register is reset too, because out_data is decoded from it and must read 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            word  <= '0;
            idx   <= '0;
            phase <= '0;
        end else if (accept) begin
            word  <= bus.in_word;
            idx   <= '0;
            phase <= '0;
        end else if (advance) begin
            case (phase)
                2'd1:    word <= word << 5;
                2'd2:    word <= word << 6;
                default: word <= word << 4;
            endcase
            idx   <= bus.out_last ? 5'd0 : idx + 5'd1;
            phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        end
    end

`ifdef UNPACK_SUM_EN
    // acc holds the total of the fields already accepted; out_sum adds the one on display.
    logic [11:0] acc;

    always_ff @(posedge clk) begin
        if (reset || accept) acc <= '0;
        else if (advance)    acc <= out_sum;
    end

    assign out_sum = acc + {{4{field_ext[7]}}, field_ext};
`endif
endmodule

// File: tb/tb_expression_unpacker.sv
// Directed bench for expression_unpacker: reset, extension patterns, backpressure,
// back-to-back words and mid-word reset; out_sum checked when UNPACK_SUM_EN is defined.
module tb_expression_unpacker;
    logic clk = 1'b0;
    logic reset;
    logic busy;
`ifdef UNPACK_SUM_EN
    logic [11:0] out_sum;
`endif
    int checks = 0;
    int errors = 0;

    localparam logic [89:0] ALL_ONES = {90{1'b1}};
    localparam logic [89:0] WORD_A   = 90'h2AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [89:0] WORD_B   = 90'h1FE_DCBA_9876_5432_1000_FFFF;
    localparam logic [89:0] WORD_BP  = 90'h3A5_0F0F_1234_8765_ABCD_0246;

    expression_unpacker_if bus ();

    expression_unpacker dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
`ifdef UNPACK_SUM_EN
        .out_sum(out_sum),
`endif
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Reference extraction straight from the documented bit positions.
    function automatic logic [7:0] exp_data(input logic [89:0] w, input int k);
        int          pos;
        int          wd;
        logic [89:0] s;
        logic [7:0]  m;
        logic [7:0]  v;
        pos = 89;
        for (int j = 0; j < k; j++) pos -= 4 + j % 3;
        wd = 4 + k % 3;
        s  = w >> (pos - wd + 1);
        m  = 8'((1 << wd) - 1);
        v  = s[7:0] & m;
        if (((k / 3) % 2) == 1 && s[wd-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [11:0] exp_sum(input logic [89:0] w, input int k);
        int total;
        total = 0;
        for (int j = 0; j <= k; j++) total += int'($signed(exp_data(w, j)));
        return 12'(total);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({bus.out_data, bus.out_idx, bus.out_signed, bus.out_last} !== 15'd0) begin errors++; $display("FAIL reset_outputs got data=%h idx=%0d signed=%b last=%b want all 0", bus.out_data, bus.out_idx, bus.out_signed, bus.out_last); end
`ifdef UNPACK_SUM_EN
        checks++; if (out_sum !== 12'd0) begin errors++; $display("FAIL reset_out_sum got %h want 000", out_sum); end
`endif
    endtask

    task automatic test_all_ones();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_word   = ALL_ONES;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 18; k++) begin
            logic [7:0] want;
            if ((k / 3) % 2 == 1) want = 8'hFF;
            else if (k % 3 == 0)  want = 8'h0F;
            else if (k % 3 == 1)  want = 8'h1F;
            else                  want = 8'h3F;
            checks++; if (bus.out_valid !== 1'b1 || busy !== 1'b1 || bus.out_idx !== 5'(k) || bus.out_data !== want) begin errors++; $display("FAIL ones_beat k=%0d got valid=%b busy=%b idx=%0d data=%h want 1 1 %0d %h", k, bus.out_valid, busy, bus.out_idx, bus.out_data, k, want); end
            checks++; if (bus.out_last !== (k == 17) || bus.out_signed !== ((k / 3) % 2 == 1)) begin errors++; $display("FAIL ones_flags k=%0d got last=%b signed=%b", k, bus.out_last, bus.out_signed); end
`ifdef UNPACK_SUM_EN
            if (k == 17) begin
                checks++; if (out_sum !== 12'h13E) begin errors++; $display("FAIL ones_sum got %h want 13e", out_sum); end
            end
`endif
            @(negedge clk);
        end
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL ones_idle got valid=%b busy=%b in_ready=%b want 0 0 1", bus.out_valid, busy, bus.in_ready); end
    endtask

    task automatic run_hand_word(input string name, input logic [89:0] w, input logic [7:0] want_tab [18]);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_word   = w;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 18; k++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'(k) || bus.out_data !== want_tab[k]) begin errors++; $display("FAIL %s k=%0d got valid=%b idx=%0d data=%h want 1 %0d %h", name, k, bus.out_valid, bus.out_idx, bus.out_data, k, want_tab[k]); end
            @(negedge clk);
        end
    endtask

    task automatic test_single_bit();
        logic [7:0] tab [18];
        for (int k = 0; k < 18; k++) tab[k] = 8'h00;
        tab[0] = 8'h01;
        run_hand_word("single_bit", 90'h1 << 86, tab);
    endtask

    task automatic test_signed_min();
        logic [7:0] tab [18];
        for (int k = 0; k < 18; k++) tab[k] = 8'h00;
        tab[3]  = 8'hF8;
        tab[4]  = 8'hF0;
        tab[11] = 8'hE0;
        run_hand_word("signed_min", (90'h1 << 74) | (90'h1 << 70) | (90'h1 << 35), tab);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_word   = WORD_BP;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 18; k++) begin
            int cycles;
            cycles = (k == 4) ? 4 : 1;
            for (int c = 0; c < cycles; c++) begin
                bus.out_ready = (c == cycles - 1);
                checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'(k) || bus.out_data !== exp_data(WORD_BP, k) || bus.out_last !== (k == 17)) begin errors++; $display("FAIL backpressure k=%0d c=%0d got valid=%b idx=%0d data=%h want 1 %0d %h", k, c, bus.out_valid, bus.out_idx, bus.out_data, k, exp_data(WORD_BP, k)); end
                if (c < cycles - 1) begin
                    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL backpressure_in_ready c=%0d got %b want 0", c, bus.in_ready); end
                end
`ifdef UNPACK_SUM_EN
                checks++; if (out_sum !== exp_sum(WORD_BP, k)) begin errors++; $display("FAIL backpressure_sum k=%0d got %h want %h", k, out_sum, exp_sum(WORD_BP, k)); end
`endif
                @(negedge clk);
            end
        end
        bus.out_ready = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL backpressure_end got valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_word   = WORD_A;
        @(negedge clk);
        bus.in_word = WORD_B;
        for (int j = 0; j < 36; j++) begin
            logic [89:0] w;
            int          k;
            w = (j < 18) ? WORD_A : WORD_B;
            k = j % 18;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'(k) || bus.out_data !== exp_data(w, k) || bus.out_signed !== ((k / 3) % 2 == 1)) begin errors++; $display("FAIL b2b j=%0d got valid=%b idx=%0d data=%h want 1 %0d %h", j, bus.out_valid, bus.out_idx, bus.out_data, k, exp_data(w, k)); end
            if (j == 5 || j == 17) begin
                checks++; if (bus.in_ready !== (j == 17)) begin errors++; $display("FAIL b2b_in_ready j=%0d got %b want %b", j, bus.in_ready, j == 17); end
            end
`ifdef UNPACK_SUM_EN
            checks++; if (out_sum !== exp_sum(w, k)) begin errors++; $display("FAIL b2b_sum j=%0d got %h want %h", j, out_sum, exp_sum(w, k)); end
`endif
            if (j == 18) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end got valid=%b busy=%b want 0 0", bus.out_valid, busy); end
    endtask

    task automatic test_reset_mid_word();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_word   = ALL_ONES;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (bus.out_idx !== 5'd9 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre got idx=%0d valid=%b want 9 1", bus.out_idx, bus.out_valid); end
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_word  = WORD_A;
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midreset_post got valid=%b in_ready=%b busy=%b want 0 1 0", bus.out_valid, bus.in_ready, busy); end
        checks++; if (bus.out_idx !== 5'd0 || bus.out_data !== 8'h00 || bus.out_last !== 1'b0) begin errors++; $display("FAIL midreset_outputs got idx=%0d data=%h last=%b want 0 00 0", bus.out_idx, bus.out_data, bus.out_last); end
        bus.in_valid = 1'b1;
        bus.in_word  = 90'h1 << 86;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'd0 || bus.out_data !== 8'h01) begin errors++; $display("FAIL midreset_fresh got valid=%b idx=%0d data=%h want 1 0 01", bus.out_valid, bus.out_idx, bus.out_data); end
        repeat (18) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_fresh_end got valid=%b want 0", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_bit();
        test_signed_min();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
